// File: rtl/spi_bus_pkg.sv
// ============================================================================
// Module   : spi_bus_pkg
// Purpose  : Shared widths, command-byte layout and FSM encoding for the
//            SPI-to-parallel-bus bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_bus_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        RD_WAIT  = 3'd2,
        DATA     = 3'd3,
        WR_PULSE = 3'd4,
        DRAIN    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchronizer for an asynchronous input, with one-cycle
//            rise/fall pulses taken from a history flop. SYNC_STAGES >= 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;

endmodule

`default_nettype wire

// File: rtl/spi_bus_bridge.sv
// ============================================================================
// Module   : spi_bus_bridge
// Purpose  : Oversampled SPI-slave (mode 0) that turns {R/W,addr},{data}
//            frames into timed parallel bus read/write strobes.
//            Optional: SPI_BUS_AUTO_INC_EN enables address auto-increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_bus_bridge
    import spi_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int READ_LAT    = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_read_n,
    output logic              bus_write_n,
    output logic              frame_err
);

`ifdef SPI_BUS_AUTO_INC_EN
    localparam logic c_AUTO_INC = 1'b1;
`else
    localparam logic c_AUTO_INC = 1'b0;
`endif
    localparam logic [7:0] c_RD_LAST  = 8'(READ_LAT - 1);
    localparam logic [7:0] c_WR_LAST  = 8'(WRITE_PULSE);
    localparam logic [2:0] c_BIT_LAST = 3'(DATA_W - 1);

    logic w_sck_level_unused, w_sck_rise, w_sck_fall;
    logic w_nss_lvl, w_nss_rise, w_nss_fall;
    logic w_mosi_lvl, w_mosi_rise_unused, w_mosi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(reset), .i_async(sck),
        .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
        .clk(clk), .rst(reset), .i_async(nss),
        .o_level(w_nss_lvl), .o_rise(w_nss_rise), .o_fall(w_nss_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(reset), .i_async(mosi),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t              r_state, w_state_nxt, w_idle_tgt;
    logic [2:0]          r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0]   r_rx, w_rx_nxt, r_tx, w_tx_nxt, r_wdata, w_wdata_nxt, w_rx_shift;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic                r_rw, w_rw_nxt, r_read_n, w_read_n_nxt, r_write_n, w_write_n_nxt;
    logic                r_miso, w_miso_nxt, r_err, w_err_nxt;
    logic                r_nss_rose, w_nss_rose_nxt, r_multi, w_multi_nxt;
    logic                w_quiet_end;

    assign w_rx_shift  = {r_rx[DATA_W-2:0], w_mosi_lvl};
    assign w_idle_tgt  = w_nss_fall ? CMD : IDLE;
    // With auto-increment, nss rising between bytes ends the burst cleanly.
    assign w_quiet_end = c_AUTO_INC & r_multi & (r_bitcnt == 3'd0);

    always_comb begin
        w_state_nxt    = r_state;
        w_bitcnt_nxt   = r_bitcnt;
        w_rx_nxt       = r_rx;
        w_tx_nxt       = r_tx;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_read_n_nxt   = r_read_n;
        w_write_n_nxt  = r_write_n;
        w_miso_nxt     = r_miso;
        w_err_nxt      = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_nss_rose_nxt = r_nss_rose;
        w_multi_nxt    = r_multi;

        if (w_nss_rise && (r_state == CMD || r_state == RD_WAIT || r_state == DATA)) begin
            w_err_nxt    = ~w_quiet_end;
            w_read_n_nxt = 1'b1;
            w_cnt_nxt    = 8'd0;
            w_multi_nxt  = 1'b0;
            w_state_nxt  = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_miso_nxt  = 1'b0;
                    w_multi_nxt = 1'b0;
                    if (w_nss_fall) begin
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = CMD;
                    end
                end
                CMD: begin
                    if (w_sck_rise) begin
                        w_rx_nxt     = w_rx_shift;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == c_BIT_LAST) begin
                            w_addr_nxt  = w_rx_shift[ADDR_W-1:0];
                            w_rw_nxt    = w_rx_shift[CMD_RW_BIT];
                            w_cnt_nxt   = 8'd0;
                            w_state_nxt = w_rx_shift[CMD_RW_BIT] ? RD_WAIT : DATA;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_read_n) begin
                        w_read_n_nxt = 1'b0;
                    end else if (r_cnt == c_RD_LAST) begin
                        w_tx_nxt     = bus_rdata;
                        w_read_n_nxt = 1'b1;
                        w_cnt_nxt    = 8'd0;
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (r_rw) begin
                        if (w_sck_fall) begin
                            w_miso_nxt = r_tx[DATA_W-1];
                            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (w_sck_rise) begin
                            w_bitcnt_nxt = r_bitcnt + 3'd1;
                            if (r_bitcnt == c_BIT_LAST) begin
                                if (c_AUTO_INC) begin
                                    w_addr_nxt  = r_addr + 7'd1;
                                    w_multi_nxt = 1'b1;
                                    w_state_nxt = RD_WAIT;
                                end else begin
                                    w_state_nxt = DRAIN;
                                end
                            end
                        end
                    end else if (w_sck_rise) begin
                        w_rx_nxt     = w_rx_shift;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == c_BIT_LAST) begin
                            w_wdata_nxt    = w_rx_shift;
                            w_cnt_nxt      = 8'd0;
                            w_nss_rose_nxt = 1'b0;
                            w_state_nxt    = WR_PULSE;
                        end
                    end
                end
                WR_PULSE: begin
                    // Setup cycle, WRITE_PULSE low cycles, then one hold cycle.
                    w_nss_rose_nxt = r_nss_rose | w_nss_rise;
                    if (r_cnt == 8'd0) begin
                        w_write_n_nxt = 1'b0;
                        w_cnt_nxt     = 8'd1;
                    end else if (r_cnt < c_WR_LAST) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end else if (r_cnt == c_WR_LAST) begin
                        w_write_n_nxt = 1'b1;
                        w_cnt_nxt     = r_cnt + 8'd1;
                    end else begin
                        w_cnt_nxt = 8'd0;
                        if (r_nss_rose | w_nss_rise) begin
                            w_multi_nxt  = 1'b0;
                            w_bitcnt_nxt = 3'd0;
                            w_state_nxt  = w_idle_tgt;
                        end else if (c_AUTO_INC) begin
                            w_addr_nxt   = r_addr + 7'd1;
                            w_multi_nxt  = 1'b1;
                            w_bitcnt_nxt = 3'd0;
                            w_state_nxt  = DATA;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_nss_lvl) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bitcnt   <= 3'd0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_read_n   <= 1'b1;
            r_write_n  <= 1'b1;
            r_miso     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
            r_nss_rose <= 1'b0;
            r_multi    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_rx       <= w_rx_nxt;
            r_tx       <= w_tx_nxt;
            r_rw       <= w_rw_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_read_n   <= w_read_n_nxt;
            r_write_n  <= w_write_n_nxt;
            r_miso     <= w_miso_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
            r_nss_rose <= w_nss_rose_nxt;
            r_multi    <= w_multi_nxt;
        end
    end

    assign miso_oe     = ~w_nss_lvl;
    assign miso        = miso_oe & r_miso;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_read_n  = r_read_n;
    assign bus_write_n = r_write_n;
    assign frame_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_bridge.sv
// ============================================================================
// Module   : tb_spi_bus_bridge
// Purpose  : Directed self-checking bench for spi_bus_bridge (mode-0 frames at
//            half-period 8 clk); honours SPI_BUS_AUTO_INC_EN for expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_bus_bridge;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       nss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata = 8'h3C;
    logic       bus_read_n, bus_write_n, frame_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_bus_bridge dut (
        .clk(clk), .reset(reset), .sck(sck), .nss(nss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_read_n(bus_read_n), .bus_write_n(bus_write_n),
        .frame_err(frame_err)
    );

    // Bus monitor: strobe widths, events, logged address/data, stability.
    int         rd_low = 0, wr_low = 0, rd_evt = 0, wr_evt = 0, err_cnt = 0, stab_viol = 0;
    logic [6:0] rd_log_addr = '0;
    logic [6:0] wr_log_addr [0:15];
    logic [7:0] wr_log_data [0:15];
    logic [6:0] p_addr = '0;
    logic [7:0] p_wdata = '0;
    logic       p_rd_n = 1'b1, p_wr_n = 1'b1;

    always @(negedge clk) begin
        if (!bus_read_n) begin
            rd_low++;
            if (p_rd_n) begin
                rd_log_addr = bus_addr;
                rd_evt++;
            end
        end
        if (!bus_write_n) begin
            wr_low++;
            if (p_wr_n) begin
                wr_log_addr[wr_evt % 16] = bus_addr;
                wr_log_data[wr_evt % 16] = bus_wdata;
                wr_evt++;
            end
        end
        if (frame_err) err_cnt++;
        if ((!bus_read_n || !bus_write_n || !p_rd_n || !p_wr_n) && bus_addr != p_addr) stab_viol++;
        if ((!bus_write_n || !p_wr_n) && bus_wdata != p_wdata) stab_viol++;
        p_addr  = bus_addr;
        p_wdata = bus_wdata;
        p_rd_n  = bus_read_n;
        p_wr_n  = bus_write_n;
    end

    int s_rd_low, s_wr_low, s_rd_evt, s_wr_evt, s_err, s_stab;

    task automatic snap();
        s_rd_low = rd_low;
        s_wr_low = wr_low;
        s_rd_evt = rd_evt;
        s_wr_evt = wr_evt;
        s_err    = err_cnt;
        s_stab   = stab_viol;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shifts nbits of a left-aligned 24-bit pattern; rx collects miso before byte-1 rises.
    task automatic spi_frame(input logic [23:0] bits, input int nbits, input bit nss_early,
                             output logic [7:0] rx);
        rx  = 8'h00;
        nss = 1'b0;
        clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[23-i];
            clks(HALF);
            if (i >= 8 && i < 16) rx = {rx[6:0], miso};
            sck = 1'b1;
            if (nss_early && i == nbits - 1) begin
                clks(1);
                nss = 1'b1;
                clks(HALF - 1);
            end else begin
                clks(HALF);
            end
            sck = 1'b0;
        end
        clks(HALF);
        nss  = 1'b1;
        mosi = 1'b0;
        clks(4 * HALF);
    endtask

    logic [7:0] rx;
    logic [7:0] cmd_rd = 8'h83;
    int         k;

    initial begin
        reset = 1'b1;
        clks(3);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_miso", miso, 0);
        chk("rst_read_n", bus_read_n, 1);
        chk("rst_write_n", bus_write_n, 1);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        clks(4);

        // Plain write 0x05 <- 0xA5
        snap();
        spi_frame({8'h05, 8'hA5, 8'h00}, 16, 1'b0, rx);
        chk("wr_events", wr_evt - s_wr_evt, 1);
        chk("wr_low_cycles", wr_low - s_wr_low, 2);
        chk("wr_no_read", rd_low - s_rd_low, 0);
        chk("wr_no_err", err_cnt - s_err, 0);
        chk("wr_addr", wr_log_addr[s_wr_evt % 16], 8'h05);
        chk("wr_data", wr_log_data[s_wr_evt % 16], 8'hA5);
        chk("wr_stable", stab_viol - s_stab, 0);

        // Read from 0x03, peripheral returns 0x3C
        snap();
        spi_frame({cmd_rd, 8'h00, 8'h00}, 16, 1'b0, rx);
        chk("rd_events", rd_evt - s_rd_evt, 1);
        chk("rd_low_cycles", rd_low - s_rd_low, 2);
        chk("rd_addr", rd_log_addr, 8'h03);
        chk("rd_miso_byte", rx, 8'h3C);
        chk("rd_no_write", wr_evt - s_wr_evt, 0);
        chk("rd_no_err", err_cnt - s_err, 0);
        chk("rd_stable", stab_viol - s_stab, 0);

        // Abort after 5 command bits, then a clean write 0x01 <- 0xFF
        snap();
        spi_frame({8'h05, 8'h00, 8'h00}, 5, 1'b0, rx);
        chk("abort_err_pulse", err_cnt - s_err, 1);
        chk("abort_no_read", rd_low - s_rd_low, 0);
        chk("abort_no_write", wr_low - s_wr_low, 0);
        snap();
        spi_frame({8'h01, 8'hFF, 8'h00}, 16, 1'b0, rx);
        chk("post_abort_wr_events", wr_evt - s_wr_evt, 1);
        chk("post_abort_addr", wr_log_addr[s_wr_evt % 16], 8'h01);
        chk("post_abort_data", wr_log_data[s_wr_evt % 16], 8'hFF);
        chk("post_abort_no_err", err_cnt - s_err, 0);

        // nss rises while the write strobe is active
        snap();
        spi_frame({8'h22, 8'h5C, 8'h00}, 16, 1'b1, rx);
        chk("early_nss_wr_events", wr_evt - s_wr_evt, 1);
        chk("early_nss_wr_low", wr_low - s_wr_low, 2);
        chk("early_nss_no_err", err_cnt - s_err, 0);
        chk("early_nss_data", wr_log_data[s_wr_evt % 16], 8'h5C);

        // Reset pulse while bus_read_n is low
        nss = 1'b0;
        clks(HALF);
        for (int i = 0; i < 8; i++) begin
            mosi = cmd_rd[7-i];
            clks(HALF);
            sck = 1'b1;
            if (i < 7) begin
                clks(HALF);
                sck = 1'b0;
            end
        end
        k = 0;
        while (bus_read_n && k < 20) begin
            clks(1);
            k++;
        end
        chk("mid_rd_strobe_seen", bus_read_n, 0);
        reset = 1'b1;
        nss   = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        clks(1);
        chk("mid_rst_read_n", bus_read_n, 1);
        chk("mid_rst_miso_oe", miso_oe, 0);
        chk("mid_rst_addr", bus_addr, 0);
        reset = 1'b0;
        clks(4 * HALF);
        snap();
        spi_frame({8'h10, 8'h5A, 8'h00}, 16, 1'b0, rx);
        chk("post_rst_wr_events", wr_evt - s_wr_evt, 1);
        chk("post_rst_addr", wr_log_addr[s_wr_evt % 16], 8'h10);
        chk("post_rst_data", wr_log_data[s_wr_evt % 16], 8'h5A);

        // Three-byte write starting at the top address
        snap();
        spi_frame({8'h7F, 8'h11, 8'h22}, 24, 1'b0, rx);
        chk("burst_first_addr", wr_log_addr[s_wr_evt % 16], 8'h7F);
        chk("burst_first_data", wr_log_data[s_wr_evt % 16], 8'h11);
        chk("burst_no_err", err_cnt - s_err, 0);
`ifdef SPI_BUS_AUTO_INC_EN
        chk("burst_wr_events", wr_evt - s_wr_evt, 2);
        chk("burst_wrap_addr", wr_log_addr[(s_wr_evt + 1) % 16], 8'h00);
        chk("burst_second_data", wr_log_data[(s_wr_evt + 1) % 16], 8'h22);
`else
        chk("burst_wr_events", wr_evt - s_wr_evt, 1);
        chk("burst_addr_held", bus_addr, 8'h7F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
